key_emulator: RTL
=================

Name: key_emulator

Overview:
- Transmit side of the key/pulse path: turns a scripted press request into a physical-style key waveform, i.e. the level signal that key_detector expects on its key input.
- Used by the bug_finder controller to replay N key presses without a human on the button.
- Each press is held for a fixed number of cycles and followed by a fixed release gap, so a downstream key_detector sees exactly N distinct presses.

Parameters:
- COUNT_W, 4: width of the press-count request field.
- HOLD_LENGTH, 5: cycles key is held at 1 per press; legal range >= 1.
- GAP_LENGTH, 5: cycles key is held at 0 between presses and after the last press; legal range >= 1.
- BOUNCE_CYCLES, 3: bounce cycles at the start of each press; used only with KEY_EMU_BOUNCE_EN.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  press request present.
- req_count  in  COUNT_W  number of presses requested.
- req_ready  out  1  emulator can accept a request.
- abort  in  1  cancel the current sequence.
- key  out  1  emulated key level, registered; 1 = pressed.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse when a sequence completes normally.
- presses_left  out  COUNT_W  presses not yet completed.

Behaviour:
- Interface (already decided): one clock, clock; reset is asynchronous and active-high.
- Reset: state S_IDLE. key=0, busy=0, done=0, presses_left=0, internal cycle counter=0, req_ready=1.
- Cycle counter is 26 bits. It clears on every state change.
- States:
  - S_IDLE: req_ready=1, key=0, busy=0.
  - S_PRESS: key=1, busy=1.
  - S_RELEASE: key=0, busy=1.
- Handshake: a transfer occurs on a rising edge where req_valid=1 and req_ready=1. req_ready is combinational and equals (state==S_IDLE).
- Accept with req_count=N>0:
  - Next cycle: state S_PRESS, presses_left=N, key=1.
  - Latency from the accepting edge to key rising is 1 cycle.
- S_PRESS to S_RELEASE: after the counter reaches HOLD_LENGTH-1, so key is high for exactly HOLD_LENGTH cycles.
- S_RELEASE ends after GAP_LENGTH cycles; presses_left decrements by 1 at that edge.
  - If the result is nonzero: go to S_PRESS.
  - If the result is 0: go to S_IDLE and assert done for that first S_IDLE cycle.
- Total sequence length: N*(HOLD_LENGTH+GAP_LENGTH) cycles.
- Accept with req_count=0: no key activity. Stays S_IDLE; done=1 on the following cycle.
- done is a one-cycle pulse. A new request may be accepted in the same cycle done=1; done still deasserts next cycle.
- abort=1 (any state, sampled on the edge): next state S_IDLE, key=0, presses_left=0, counter=0. No done.
  - abort has priority over a simultaneous request; the request is not accepted that cycle.
- req_valid while busy: ignored (req_ready=0). The requester holds req_valid until the transfer.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronous), and key drops without completing the gap.
- presses_left reaching the max value 2^COUNT_W-1 is legal; there is no wrap because only decrement occurs.

Optional Feature:
- Macro: KEY_EMU_BOUNCE_EN.
- Defined:
  - S_PRESS lasts BOUNCE_CYCLES+HOLD_LENGTH cycles.
  - During the first BOUNCE_CYCLES cycles, key = NOT counter[0], giving 1,0,1,... Then key holds 1 for HOLD_LENGTH cycles.
  - Models a mechanical bounce at press.
- Not defined: BOUNCE_CYCLES is ignored, and S_PRESS is exactly HOLD_LENGTH cycles of solid 1.

Test Plan:
- Reset, then req_count=3 with HOLD=5, GAP=5 -> key shows 3 high pulses of 5 cycles each separated by 5 low cycles; presses_left goes 3,2,1,0; done pulses once, 30 cycles after the first key rise.
- req_count=0 accepted -> key stays 0, busy stays 0, done=1 for exactly one cycle the cycle after acceptance.
- Request with count=4, abort asserted on 2nd press cycle 2 -> next cycle key=0, busy=0, presses_left=0; done never asserts.
- req_valid held with count=2 during an active count=1 sequence -> accepted only in the done cycle; second sequence key rises the next cycle.
- Async reset pulse mid-S_PRESS (no clock edge) -> key=0, busy=0, req_ready=1 immediately.
- With KEY_EMU_BOUNCE_EN, BOUNCE_CYCLES=3, HOLD=5, count=1 -> key sequence 1,0,1,1,1,1,1,1, then 5 zeros, then done.

Source files
------------

// File: rtl/key_emulator.sv
// key_emulator: transmit side of the key/pulse path.
//
// Turns a scripted press request (req_count presses) into a level waveform on
// `key` that a downstream key_detector sees as exactly req_count distinct
// presses. Each press holds key high for HOLD_LENGTH cycles and is followed by
// GAP_LENGTH low cycles, including after the last press.
//
// Optional build macro KEY_EMU_BOUNCE_EN: when defined, every press begins with
// BOUNCE_CYCLES cycles of 1,0,1,... chatter before the solid HOLD_LENGTH high
// phase, modelling a mechanical contact bounce. When undefined, BOUNCE_CYCLES
// has no effect.
//
// Request handshake: a transfer happens on a rising clock edge where
// req_valid=1 and req_ready=1 and abort=0. req_ready is combinational and is
// high exactly while the emulator is idle. A requester presenting req_valid
// while the emulator is busy simply holds it until the transfer.
module key_emulator #(
  parameter int COUNT_W       = 4,
  parameter int HOLD_LENGTH   = 5,
  parameter int GAP_LENGTH    = 5,
  parameter int BOUNCE_CYCLES = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req_valid,
  input  logic [COUNT_W-1:0] req_count,
  output logic               req_ready,
  input  logic               abort,
  output logic               key,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] presses_left
);

  // Bounce phase length actually applied to each press in this build.
`ifdef KEY_EMU_BOUNCE_EN
  localparam int BOUNCE_ON = 1;
`else
  localparam int BOUNCE_ON = 0;
`endif
  localparam int BOUNCE_LEN   = BOUNCE_CYCLES * BOUNCE_ON;
  localparam int PRESS_CYCLES = BOUNCE_LEN + HOLD_LENGTH;

  // Terminal counter values for each timed phase.
  localparam logic [25:0] PRESS_LAST = 26'(PRESS_CYCLES - 1);
  localparam logic [25:0] GAP_LAST   = 26'(GAP_LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESS   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [25:0]        cnt_q;
  logic [25:0]        cnt_d;
  logic [COUNT_W-1:0] left_q;
  logic [COUNT_W-1:0] left_d;
  logic [COUNT_W-1:0] left_dec;
  logic               key_q;
  logic               key_d;
  logic               done_q;
  logic               done_d;
  logic               accept;
  logic               in_bounce;

  assign req_ready    = (state_q == S_IDLE);
  assign accept       = req_valid && req_ready && !abort;
  assign left_dec     = left_q - COUNT_W'(1);
  assign busy         = (state_q != S_IDLE);
  assign key          = key_q;
  assign done         = done_q;
  assign presses_left = left_q;

  // Bounce window exists only when the bounce phase has nonzero length.
  generate
    if (BOUNCE_LEN > 0) begin : g_bounce
      assign in_bounce = (cnt_d < 26'(BOUNCE_LEN));
    end else begin : g_no_bounce
      assign in_bounce = 1'b0;
    end
  endgenerate

  // Next-state, counter, press count and done pulse; abort overrides all.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      left_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (accept) begin
            if (req_count != '0) begin
              state_d = S_PRESS;
              left_d  = req_count;
            end else begin
              // Empty request: no key activity, just acknowledge completion.
              done_d = 1'b1;
            end
          end
        end
        S_PRESS: begin
          if (cnt_q == PRESS_LAST) begin
            state_d = S_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 26'd1;
          end
        end
        S_RELEASE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d  = '0;
            left_d = left_dec;
            if (left_dec != '0) begin
              state_d = S_PRESS;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 26'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          left_d  = '0;
        end
      endcase
    end
  end

  // Key level for the coming cycle: high while pressing, except the
  // alternating chatter at the start of a press when bounce is enabled.
  always_comb begin
    key_d = 1'b0;
    if (state_d == S_PRESS) begin
      key_d = in_bounce ? ~cnt_d[0] : 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      left_q  <= '0;
      key_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

endmodule
